// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares a single-port 320x240 frame buffer between display line fetch (priority) and pixel writes
// Ports:
//    vgaClk, reset                    clock, synchronous active-high reset
//    frameStart, lineStart, pixelPop  VGA timing strobes and pixel consume
//    pixelData, pixelValid, underflow show-ahead FIFO head, non-empty flag, sticky pop-on-empty
//    wrReq, wrAddr, wrData, wrGrant   writer request held until granted
//    ramAddr, ramWe, ramWData         RAM command, read data returns one cycle later on ramRData
module framebuffer_arbiter #(
   parameter int H_SRC = 320,
   parameter int V_SRC = 240,
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8,
   parameter int FIFO_DEPTH = 4
)(
   input  logic              vgaClk,
   input  logic              reset,
   input  logic              frameStart,
   input  logic              lineStart,
   input  logic              pixelPop,
   output logic [DATA_W-1:0] pixelData,
   output logic              pixelValid,
   output logic              underflow,
   input  logic              wrReq,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   output logic              wrGrant,
   output logic [ADDR_W-1:0] ramAddr,
   output logic              ramWe,
   output logic [DATA_W-1:0] ramWData,
   input  logic [DATA_W-1:0] ramRData
);
   localparam int CNT_W = $clog2(H_SRC + 1);
   localparam int LC_W = $clog2(2 * V_SRC);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] H_END = CNT_W'(H_SRC);
   localparam logic [LC_W-1:0] LC_MAX = LC_W'(2 * V_SRC - 1);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_SRC);
   localparam logic [ADDR_W-1:0] N_WORDS = ADDR_W'(H_SRC * V_SRC);
   localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);
   logic [CNT_W-1:0] fetchCnt;
   logic [LC_W-1:0] lineCount, nextCount;
   logic [ADDR_W-1:0] lineBase, nextBase, rdAddr, lastAddr;
   logic firstLine, inFlight, rdGo, flush, push, pop;
   logic [PW-1:0] rdPtr, wrPtr;
   logic [PW:0] fifoCount;
   logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
   always_comb begin
      // in-flight read reserves a FIFO slot so a returning pixel always fits
      rdGo = !reset && fetchCnt < H_END && fifoCount + {{PW{1'b0}}, inFlight} < DEPTH;
      wrGrant = !reset && !rdGo && wrReq;
      ramWe = wrGrant && wrAddr < N_WORDS;
      ramAddr = rdGo ? rdAddr : wrGrant ? wrAddr : lastAddr;
      ramWData = wrData;
      flush = frameStart || lineStart;
      push = inFlight && !flush;
      pop = pixelPop && fifoCount != '0 && !flush;
      nextCount = lineCount == LC_MAX ? lineCount : lineCount + LC_W'(1);
      // each source line is shown twice: advance only on even displayed lines
      nextBase = (firstLine || frameStart) ? '0 : nextCount[0] ? lineBase : lineBase + H_STEP;
      pixelValid = fifoCount != '0;
      pixelData = fifoMem[rdPtr];
   end
   always_ff @(posedge vgaClk)
      if (push) fifoMem[wrPtr] <= ramRData;
   always_ff @(posedge vgaClk)
      if (reset) begin
         fetchCnt <= H_END;
         lineCount <= '0;
         lineBase <= '0;
         rdAddr <= '0;
         lastAddr <= '0;
         firstLine <= 1'b1;
         inFlight <= 1'b0;
         rdPtr <= '0;
         wrPtr <= '0;
         fifoCount <= '0;
         underflow <= 1'b0;
      end else begin
         lastAddr <= ramAddr;
         inFlight <= rdGo && !flush;
         if (rdGo) begin
            rdAddr <= rdAddr + ADDR_W'(1);
            fetchCnt <= fetchCnt + CNT_W'(1);
         end
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop) rdPtr <= rdPtr + PW'(1);
         fifoCount <= fifoCount + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         if (pixelPop && fifoCount == '0 && !flush) underflow <= 1'b1;
         if (frameStart) begin
            firstLine <= 1'b1;
            underflow <= 1'b0;
            fetchCnt <= H_END;
         end
         // a coincident frameStart makes this the first line of the new frame
         if (lineStart) begin
            firstLine <= 1'b0;
            lineCount <= (firstLine || frameStart) ? '0 : nextCount;
            lineBase <= nextBase;
            rdAddr <= nextBase;
            fetchCnt <= '0;
         end
         if (flush) begin
            fifoCount <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
         end
      end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: randomized self-checking bench with a frame-buffer RAM model and line-address reference
module tb_framebuffer_arbiter;
   localparam int H = 320;
   localparam int V = 240;
   localparam int NW = H * V;
   logic vgaClk = 1'b0;
   logic reset = 1'b1, frameStart = 1'b0, lineStart = 1'b0, pixelPop = 1'b0, wrReq = 1'b0;
   logic [16:0] wrAddr = '0, ramAddr;
   logic [7:0] wrData = '0, pixelData, ramWData, ramRData;
   logic pixelValid, underflow, wrGrant, ramWe;
   logic [7:0] mem [NW];
   logic [7:0] gold [NW];
   int hits [int];
   int checks = 0, errors = 0;
   always #5 vgaClk = ~vgaClk;
   framebuffer_arbiter dut (
      .vgaClk(vgaClk), .reset(reset), .frameStart(frameStart), .lineStart(lineStart),
      .pixelPop(pixelPop), .pixelData(pixelData), .pixelValid(pixelValid), .underflow(underflow),
      .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGrant(wrGrant),
      .ramAddr(ramAddr), .ramWe(ramWe), .ramWData(ramWData), .ramRData(ramRData)
   );
   always @(posedge vgaClk) begin
      ramRData <= (ramAddr < NW) ? mem[ramAddr] : 8'h00;
      if (ramWe) begin
         mem[ramAddr] = ramWData;
         hits[int'(ramAddr)] = hits.exists(int'(ramAddr)) ? hits[int'(ramAddr)] + 1 : 1;
      end
   end
   task automatic cyc();
      @(posedge vgaClk);
      #2;
      frameStart = 1'b0;
      lineStart = 1'b0;
      pixelPop = 1'b0;
   endtask
   function automatic int expBase(int k);
      return ((k > 2 * V - 1 ? 2 * V - 1 : k) / 2) * H;
   endfunction
   task automatic fill_random();
      for (int i = 0; i < NW; i++) begin
         gold[i] = 8'($urandom);
         mem[i] = gold[i];
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) begin
         lineStart = 1'($urandom);
         pixelPop = 1'($urandom);
         cyc();
      end
      reset = 1'b0;
      #1;
      checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pixelValid); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
      checks++; if (wrGrant !== 1'b0 || ramWe !== 1'b0) begin errors++; $display("FAIL reset_wr: grant %b we %b want 0 0", wrGrant, ramWe); end
      checks++; if (ramAddr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ramAddr); end
      repeat (5) cyc();
      #1;
      checks++; if (ramAddr !== 17'd0 || pixelValid !== 1'b0) begin errors++; $display("FAIL reset_no_fetch: addr %0d valid %b want 0 0", ramAddr, pixelValid); end
   endtask
   task automatic test_first_fetch();
      for (int i = 0; i < NW; i++) begin
         mem[i] = i[7:0];
         gold[i] = i[7:0];
      end
      lineStart = 1'b1;
      #1;
      cyc();
      for (int i = 1; i <= 8; i++) begin
         #1;
         checks++; if (ramAddr !== 17'(i <= 4 ? i - 1 : 3) || ramWe !== 1'b0) begin errors++; $display("FAIL first_read L+%0d: addr %0d we %b want %0d 0", i, ramAddr, ramWe, i <= 4 ? i - 1 : 3); end
         if (i == 2) begin
            checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %b want 0", pixelValid); end
         end
         if (i >= 3) begin
            checks++; if (pixelValid !== 1'b1 || pixelData !== 8'h00) begin errors++; $display("FAIL first_head L+%0d: valid %b data %h want 1 00", i, pixelValid, pixelData); end
         end
         cyc();
      end
   endtask
   task automatic test_frame();
      int base, bad;
      fill_random();
      frameStart = 1'b1;
      #1;
      cyc();
      repeat (3) cyc();
      for (int k = 0; k <= 2 * V; k++) begin
         base = expBase(k);
         bad = 0;
         lineStart = 1'b1;
         #1;
         cyc();
         #1;
         checks++; if (ramAddr !== 17'(base) || ramWe !== 1'b0) begin errors++; $display("FAIL line_base %0d: addr %0d we %b want %0d 0", k, ramAddr, ramWe, base); end
         if (k < 2 || k == 2 * V - 1) begin
            repeat (7) cyc();
            for (int j = 0; j < H; j++) begin
               pixelPop = 1'b1;
               #1;
               if (pixelValid !== 1'b1 || pixelData !== gold[base + j]) bad++;
               cyc();
               cyc();
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL line_pixels %0d: %0d bad pixels want 0", k, bad); end
         end else begin
            repeat (4) cyc();
            #1;
            checks++; if (pixelValid !== 1'b1 || pixelData !== gold[base]) begin errors++; $display("FAIL line_head %0d: valid %b data %h want 1 %h", k, pixelValid, pixelData, gold[base]); end
         end
      end
      #1;
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL frame_underflow: got %b want 0", underflow); end
   endtask
   task automatic test_writes();
      logic [16:0] qa[$];
      logic [7:0] qd[$];
      int idx = 0, nonGrant = 0, weBad = 0, popped = 0, bad = 0, miss = 0;
      hits.delete();
      for (int n = 0; n < 800; n++) begin
         qa.push_back(17'(400 + n * 90 + int'($urandom_range(0, 89))));
         qd.push_back(8'($urandom));
      end
      frameStart = 1'b1;
      lineStart = 1'b1;
      #1;
      cyc();
      wrReq = 1'b1;
      for (int c = 0; c < 700; c++) begin
         wrAddr = qa[idx];
         wrData = qd[idx];
         pixelPop = (c >= 8 && c % 2 == 0 && popped < H);
         #1;
         if (ramWe !== wrGrant) weBad++;
         if (wrGrant !== 1'b1) nonGrant++;
         if (pixelPop) begin
            if (pixelValid !== 1'b1 || pixelData !== gold[popped]) bad++;
            popped++;
         end
         if (wrGrant === 1'b1) begin
            gold[qa[idx]] = qd[idx];
            idx++;
         end
         cyc();
      end
      wrReq = 1'b0;
      for (int i = 0; i < idx; i++)
         if (!hits.exists(int'(qa[i])) || hits[int'(qa[i])] != 1 || mem[qa[i]] !== qd[i]) miss++;
      checks++; if (nonGrant != H) begin errors++; $display("FAIL wr_read_slots: %0d non-grant cycles want %0d", nonGrant, H); end
      checks++; if (weBad != 0) begin errors++; $display("FAIL wr_we_match: %0d cycles with ramWe != wrGrant want 0", weBad); end
      checks++; if (bad != 0) begin errors++; $display("FAIL wr_pixels: %0d bad pixels want 0", bad); end
      checks++; if (miss != 0) begin errors++; $display("FAIL wr_landed: %0d writes wrong want 0", miss); end
      checks++; if (hits.size() != idx) begin errors++; $display("FAIL wr_count: %0d addresses written want %0d", hits.size(), idx); end
   endtask
   task automatic test_flush_midline();
      gold[0] = 8'h5A;
      mem[0] = 8'h5A;
      gold[320] = 8'hA5;
      mem[320] = 8'hA5;
      frameStart = 1'b1;
      lineStart = 1'b1;
      #1;
      cyc();
      repeat (10) cyc();
      lineStart = 1'b1;
      #1;
      cyc();
      repeat (4) cyc();
      lineStart = 1'b1;
      #1;
      checks++; if (pixelValid !== 1'b1 || pixelData !== 8'h5A) begin errors++; $display("FAIL flush_pre: valid %b data %h want 1 5a", pixelValid, pixelData); end
      cyc();
      #1;
      checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", pixelValid); end
      checks++; if (ramAddr !== 17'd320) begin errors++; $display("FAIL flush_newbase: addr %0d want 320", ramAddr); end
      cyc();
      #1;
      checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL flush_stale: valid %b want 0", pixelValid); end
      cyc();
      #1;
      checks++; if (pixelValid !== 1'b1 || pixelData !== 8'hA5) begin errors++; $display("FAIL flush_refill: valid %b data %h want 1 a5", pixelValid, pixelData); end
   endtask
   task automatic test_underflow();
      frameStart = 1'b1;
      #1;
      cyc();
      #1;
      checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL uf_empty: valid %b want 0", pixelValid); end
      pixelPop = 1'b1;
      cyc();
      #1;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", underflow); end
      repeat (5) cyc();
      lineStart = 1'b1;
      cyc();
      repeat (3) cyc();
      #1;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow); end
      frameStart = 1'b1;
      pixelPop = 1'b1;
      cyc();
      #1;
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", underflow); end
      lineStart = 1'b1;
      pixelPop = 1'b1;
      cyc();
      #1;
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_flush_pop: got %b want 0", underflow); end
   endtask
   task automatic test_oob_sync();
      frameStart = 1'b1;
      cyc();
      wrReq = 1'b1;
      wrAddr = 17'(NW);
      wrData = 8'($urandom);
      #1;
      checks++; if (wrGrant !== 1'b1 || ramWe !== 1'b0) begin errors++; $display("FAIL oob_write: grant %b we %b want 1 0", wrGrant, ramWe); end
      cyc();
      wrReq = 1'b0;
      frameStart = 1'b1;
      lineStart = 1'b1;
      cyc();
      #1;
      checks++; if (ramAddr !== 17'd0 || ramWe !== 1'b0) begin errors++; $display("FAIL sync_first_read: addr %0d we %b want 0 0", ramAddr, ramWe); end
      cyc();
      cyc();
      #1;
      checks++; if (pixelValid !== 1'b1 || pixelData !== gold[0]) begin errors++; $display("FAIL sync_head: valid %b data %h want 1 %h", pixelValid, pixelData, gold[0]); end
   endtask
   task automatic test_reset_midline();
      frameStart = 1'b1;
      cyc();
      pixelPop = 1'b1;
      cyc();
      lineStart = 1'b1;
      cyc();
      repeat (6) cyc();
      reset = 1'b1;
      lineStart = 1'b1;
      pixelPop = 1'b1;
      wrReq = 1'b1;
      wrAddr = 17'd500;
      cyc();
      reset = 1'b0;
      wrReq = 1'b0;
      #1;
      checks++; if (pixelValid !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rstmid_state: valid %b uf %b want 0 0", pixelValid, underflow); end
      checks++; if (wrGrant !== 1'b0 || ramWe !== 1'b0 || ramAddr !== 17'd0) begin errors++; $display("FAIL rstmid_ram: grant %b we %b addr %0d want 0 0 0", wrGrant, ramWe, ramAddr); end
      repeat (3) cyc();
      #1;
      checks++; if (ramAddr !== 17'd0 || pixelValid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: addr %0d valid %b want 0 0", ramAddr, pixelValid); end
   endtask
   initial begin
      test_reset();
      test_first_fetch();
      test_frame();
      test_writes();
      test_flush_midline();
      test_underflow();
      test_oob_sync();
      test_reset_midline();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Sequences a single-port 320×240 frame-buffer RAM between two requesters: the VGA display fetch path and the edge-detection pixel writer. Display reads always win; writes fill the idle RAM cycles. Read pixels go into a small show-ahead prefetch FIFO, and each source line is fetched twice so that 240 source lines fill 480 displayed lines. The block sits between the frame-buffer RAM, the VGA timing generator (which supplies frame/line strobes and pixel pops) and the edge-detector output stage.

## Interface
- H_SRC, 320, source pixels per line
- V_SRC, 240, source lines per frame
- ADDR_W, 17, RAM address width (H_SRC·V_SRC = 76800 words)
- DATA_W, 8, pixel width
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

Ports:
- vgaClk  in  1  sole clock
- reset  in  1  synchronous, active-high
- frameStart  in  1  one-cycle pulse, start of vertical blanking before line 0
- lineStart  in  1  one-cycle pulse, ≥8 cycles before first pixelPop of each displayed line
- pixelPop  in  1  display consumes FIFO head this cycle
- pixelData  out  DATA_W  FIFO head (show-ahead)
- pixelValid  out  1  FIFO not empty
- underflow  out  1  sticky: pixelPop seen while FIFO empty
- wrReq  in  1  writer request; wrAddr/wrData held stable until granted
- wrAddr  in  ADDR_W  write address
- wrData  in  DATA_W  write data
- wrGrant  out  1  write issued to RAM this cycle (combinational)
- ramAddr  out  ADDR_W  RAM address
- ramWe  out  1  RAM write enable
- ramWData  out  DATA_W  RAM write data
- ramRData  in  DATA_W  RAM read data, valid one cycle after read issue

## Operation
- Reset state: FIFO empty, pixelValid=0, underflow=0, wrGrant=0, ramWe=0, ramAddr=0, lineCount=0, firstLine=1, fetchCnt=H_SRC. Because fetchCnt=H_SRC, no reads are issued until the first lineStart.
- Line base tracking (registered lineBase, lineCount 0..2·V_SRC−1):
  - On lineStart with firstLine=1: lineBase=0, lineCount=0, firstLine←0.
  - Otherwise on lineStart: lineCount+1. lineBase advances by H_SRC only when the new lineCount is even, so each source line is shown twice.
  - lineCount saturates at 2·V_SRC−1; further lineStarts refetch the last line.
- On any lineStart:
  - Flush the FIFO and discard any in-flight read.
  - fetchCnt←0; rdAddr←lineBase (new value).
- On frameStart:
  - Flush, set firstLine=1, clear underflow, fetchCnt←H_SRC.
  - If frameStart and lineStart coincide, the pair acts as frameStart followed by a first lineStart: line 0 fetch begins.
- Arbitration, evaluated each cycle:
  - Read when fetchCnt<H_SRC and occupancy+inFlight<FIFO_DEPTH. Drive ramAddr=rdAddr, ramWe=0, inFlight←1, rdAddr+1, fetchCnt+1.
  - Otherwise, if wrReq: ramAddr=wrAddr, ramWData=wrData, ramWe=1, wrGrant=1.
  - Otherwise: ramWe=0, ramAddr holds its previous value.
- Out-of-range writes (wrAddr≥H_SRC·V_SRC) are granted but do not assert ramWe.
- The block does not provide read/write coherence within a line.
- FIFO behaviour:
  - A returning read is pushed when inFlight=1 and no flush occurs that cycle.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pop on empty sets underflow and leaves occupancy unchanged.
  - A flush in the same cycle as a pop wins, and that pop does not set underflow.

## Timing
- Read issued in cycle N → ramRData sampled in N+1 → pixelValid/pixelData updated at N+2.
- First line after lineStart (cycle L):
  - First read issues at L+1.
  - FIFO is full by L+1+FIFO_DEPTH when there are no pops.
- With pops at most every other cycle (horizontal pixel doubling), reads take ≤50% of cycles; the remaining cycles are available to wrReq.
- wrGrant is combinational from wrReq and the read decision. The writer's request is consumed on the rising edge where wrGrant=1.
- Writer starvation is bounded by FIFO_DEPTH+1 cycles once fetchCnt reaches H_SRC, or while the FIFO is full.
- reset asserted mid-line overrides all strobes in that cycle; all outputs take their reset values on the next edge.

## Test plan
- Reset then lineStart, no pops, preload RAM[i]=i[7:0] → reads to addresses 0,1,2,3 on consecutive cycles; pixelValid at L+3; pixelData=0x00; no fifth read; wrReq idle.
- frameStart, then 480 lineStarts, popping 320 pixels per line every 2nd cycle → lines 0 and 1 both show RAM[0..319]; line 479 starts at address 76480; underflow=0.
- Continuous wrReq during active fetch with pops every 2nd cycle → wrGrant in every non-read cycle; every write lands exactly once; no read cycle has ramWe=1.
- lineStart while a read is in flight and the FIFO holds 3 entries → next cycle pixelValid=0; stale return not pushed; new fetch starts at the new lineBase.
- pixelPop while empty → underflow=1 and stays 1 until frameStart; frameStart+pixelPop in the same cycle → underflow=0.
- wrReq with wrAddr=76800 → wrGrant=1, ramWe=0; simultaneous frameStart+lineStart → fetch of address 0 begins the next cycle.
